// File: rtl/mult_acc_pkg.sv
// Shared constants, state encoding and width helper for the product accumulator
// and the multiplier that feeds it.
package mult_acc_pkg;

    localparam int unsigned FRAME_LEN_DEF = 16;
    localparam int unsigned ACC_W_DEF     = 72;
    localparam int unsigned DIN_W         = 64;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } acc_state_e;

    // Bits needed to hold values 0..v-1 (minimum 1).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// Product input stream, abort, and result handshake of the product accumulator.
interface product_accumulator_if
    import mult_acc_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF
);
    logic [DIN_W-1:0] din;
    logic             din_vld;
    logic             acc_clr;
    logic [ACC_W-1:0] dout;
    logic             dout_vld;
    logic             dout_rdy;
    logic             busy;
    logic             err_ovf;

    modport master (
        output din, din_vld, acc_clr, dout_rdy,
        input  dout, dout_vld, busy, err_ovf
    );

    modport slave (
        input  din, din_vld, acc_clr, dout_rdy,
        output dout, dout_vld, busy, err_ovf
    );
endinterface

// File: rtl/acc_out_hold.sv
// One-deep result holding register with valid/ready handshake and a sticky
// flag for results overwritten before they were accepted.
module acc_out_hold #(
    parameter int unsigned W = 72
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] sum_i,
    input  logic         rdy_i,
    output logic [W-1:0] dout_o,
    output logic         vld_o,
    output logic         err_ovf_o
);

    logic [W-1:0] dout_q, dout_d;
    logic         vld_q, vld_d;
    logic         err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
            vld_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            vld_q  <= vld_d;
            err_q  <= err_d;
        end
    end

    // A new sum always wins; it is an overflow only if the old one is still unaccepted.
    always_comb begin
        dout_d = dout_q;
        vld_d  = vld_q;
        err_d  = err_q;
        if (load_i) begin
            dout_d = sum_i;
            vld_d  = 1'b1;
            if (vld_q && !rdy_i) begin
                err_d = 1'b1;
            end
        end else if (vld_q && rdy_i) begin
            vld_d = 1'b0;
        end
    end

    assign dout_o    = dout_q;
    assign vld_o     = vld_q;
    assign err_ovf_o = err_q;

endmodule

// File: rtl/product_accumulator.sv
// Sums FRAME_LEN unsigned 64-bit products per frame and hands each frame sum
// to a one-deep output register; accumulation never stalls on the output.
module product_accumulator
    import mult_acc_pkg::*;
#(
    parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
    parameter int unsigned ACC_W     = ACC_W_DEF
) (
    input  logic clk,
    input  logic rst,
    product_accumulator_if.slave bus
);

    localparam int unsigned CNT_W = clog2(FRAME_LEN);

    acc_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q;
    logic [ACC_W-1:0] sum_c;
    logic             done_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == ST_ACC);
        end
    end

    assign sum_c = acc_q + ACC_W'(bus.din);

    // Abort beats everything, including a beat arriving in the same cycle.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        done_c  = 1'b0;
        if (bus.acc_clr) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (bus.din_vld) begin
            case (state_q)
                ST_IDLE: begin
                    acc_d   = ACC_W'(bus.din);
                    cnt_d   = CNT_W'(1);
                    state_d = ST_ACC;
                end
                ST_ACC: begin
                    if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                        done_c  = 1'b1;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        acc_d = sum_c;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    acc_out_hold #(
        .W(ACC_W)
    ) u_out_hold (
        .clk       (clk),
        .rst       (rst),
        .load_i    (done_c),
        .sum_i     (sum_c),
        .rdy_i     (bus.dout_rdy),
        .dout_o    (bus.dout),
        .vld_o     (bus.dout_vld),
        .err_ovf_o (bus.err_ovf)
    );

    assign bus.busy = busy_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench: a 16-beat instance for directed frames and a 4-beat instance
// fed random multiplier products under random output stalls.
module tb_product_accumulator;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    product_accumulator_if #(.ACC_W(72)) a_if ();
    product_accumulator_if #(.ACC_W(72)) b_if ();

    product_accumulator #(.FRAME_LEN(16), .ACC_W(72)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    product_accumulator #(.FRAME_LEN(4), .ACC_W(72)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    int total = 0;
    int bad   = 0;
    logic [71:0] exp_a[$];
    logic [71:0] exp_b[$];
    logic        b_random_rdy = 1'b0;

    task automatic check(input string nm, input logic [71:0] got, input logic [71:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beats(input int n, input logic [63:0] d);
        for (int i = 0; i < n; i++) begin
            a_if.din     = d;
            a_if.din_vld = 1'b1;
            tick();
        end
        a_if.din_vld = 1'b0;
    endtask

    // Monitor for instance A: every accepted result must be the next expected one.
    always @(negedge clk) begin
        if (!rst && a_if.dout_vld && a_if.dout_rdy) begin
            if (exp_a.size() == 0) begin
                check("a_unexpected_result", a_if.dout, 72'hx);
            end else begin
                check("a_dout", a_if.dout, exp_a.pop_front());
            end
        end
    end

    // Monitor for instance B: accepted results plus hold-stable under stall.
    logic        b_prev_vld = 1'b0;
    logic        b_prev_rdy = 1'b0;
    logic [71:0] b_prev_dout = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (b_prev_vld && !b_prev_rdy) begin
                check("b_hold_vld", 72'(b_if.dout_vld), 72'd1);
                check("b_hold_dout", b_if.dout, b_prev_dout);
            end
            if (b_if.dout_vld && b_if.dout_rdy) begin
                if (exp_b.size() == 0) begin
                    check("b_unexpected_result", b_if.dout, 72'hx);
                end else begin
                    check("b_dout", b_if.dout, exp_b.pop_front());
                end
            end
        end
        b_prev_vld  = b_if.dout_vld;
        b_prev_rdy  = b_if.dout_rdy;
        b_prev_dout = b_if.dout;
    end

    // Random ready for instance B, never low for more than two cycles in a row.
    int b_stall = 0;
    always @(posedge clk) begin
        #1;
        if (b_random_rdy) begin
            if (b_stall >= 2) b_if.dout_rdy = 1'b1;
            else              b_if.dout_rdy = 1'($urandom_range(0, 1));
            b_stall = b_if.dout_rdy ? 0 : b_stall + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ma, mb;
        logic [63:0] prod;
        logic [71:0] model;
        rst = 1'b1;
        a_if.din = '0; a_if.din_vld = 1'b0; a_if.acc_clr = 1'b0; a_if.dout_rdy = 1'b1;
        b_if.din = '0; b_if.din_vld = 1'b0; b_if.acc_clr = 1'b0; b_if.dout_rdy = 1'b1;
        tick(); tick();
        check("rst_dout", a_if.dout, 72'd0);
        check("rst_vld", 72'(a_if.dout_vld), 72'd0);
        check("rst_busy", 72'(a_if.busy), 72'd0);
        check("rst_err", 72'(a_if.err_ovf), 72'd0);
        rst = 1'b0;
        tick();

        // 16 ones back-to-back, latency one cycle after the last beat
        exp_a.push_back(72'd16);
        beats(15, 64'd1);
        check("ones_busy_mid", 72'(a_if.busy), 72'd1);
        check("ones_vld_early", 72'(a_if.dout_vld), 72'd0);
        beats(1, 64'd1);
        check("ones_latency_vld", 72'(a_if.dout_vld), 72'd1);
        check("ones_busy_done", 72'(a_if.busy), 72'd0);
        tick();
        check("ones_vld_drop", 72'(a_if.dout_vld), 72'd0);
        check("ones_err", 72'(a_if.err_ovf), 72'd0);

        // maximal products, no wrap
        exp_a.push_back(72'h0F_FFFF_FFFF_FFFF_FFF0);
        beats(16, 64'hFFFF_FFFF_FFFF_FFFF);
        tick(); tick();

        // overwrite while stalled
        a_if.dout_rdy = 1'b0;
        beats(16, 64'd1);
        check("ovw_first_dout", a_if.dout, 72'd16);
        check("ovw_first_err", 72'(a_if.err_ovf), 72'd0);
        beats(16, 64'd2);
        check("ovw_second_dout", a_if.dout, 72'd32);
        check("ovw_err_set", 72'(a_if.err_ovf), 72'd1);
        exp_a.push_back(72'd32);
        a_if.dout_rdy = 1'b1;
        tick();
        check("ovw_vld_fall", 72'(a_if.dout_vld), 72'd0);

        // abort with a simultaneous beat
        exp_a.push_back(72'd48);
        beats(8, 64'd5);
        a_if.acc_clr = 1'b1; a_if.din_vld = 1'b1; a_if.din = 64'd5;
        tick();
        a_if.acc_clr = 1'b0; a_if.din_vld = 1'b0;
        check("clr_busy", 72'(a_if.busy), 72'd0);
        check("clr_vld", 72'(a_if.dout_vld), 72'd0);
        beats(16, 64'd3);
        tick(); tick();
        check("err_sticky", 72'(a_if.err_ovf), 72'd1);

        // reset with a result pending and a frame at beat 10
        a_if.dout_rdy = 1'b0;
        beats(16, 64'd1);
        beats(10, 64'd1);
        rst = 1'b1;
        tick();
        check("rst2_dout", a_if.dout, 72'd0);
        check("rst2_vld", 72'(a_if.dout_vld), 72'd0);
        check("rst2_busy", 72'(a_if.busy), 72'd0);
        check("rst2_err", 72'(a_if.err_ovf), 72'd0);
        rst = 1'b0;
        a_if.dout_rdy = 1'b1;
        exp_a.push_back(72'd16);
        beats(16, 64'd1);
        for (int i = 0; i < 50 && exp_a.size() != 0; i++) tick();
        check("a_drain", 72'(exp_a.size()), 72'd0);

        // instance B: 20 random products, random gaps, random ready
        b_random_rdy = 1'b1;
        model = '0;
        for (int i = 0; i < 20; i++) begin
            ma = $urandom;
            mb = $urandom;
            prod = 64'(ma) * 64'(mb);
            model = model + 72'(prod);
            if (i % 4 == 3) begin
                exp_b.push_back(model);
                model = '0;
            end
            b_if.din = prod;
            b_if.din_vld = 1'b1;
            tick();
            b_if.din_vld = 1'b0;
            for (int g = $urandom_range(0, 3); g > 0; g--) tick();
        end
        for (int i = 0; i < 50 && exp_b.size() != 0; i++) tick();
        check("b_drain", 72'(exp_b.size()), 72'd0);
        check("b_err", 72'(b_if.err_ovf), 72'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter FRAME_LEN, default 16, number of products summed per frame (legal range 2..65535).
REQ-002 Parameter ACC_W, default 72, accumulator/result width (must be >= 64 + clog2(FRAME_LEN)).
REQ-003 Port clk  input  1  sole clock; all logic rising-edge.
REQ-004 Port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 Port din  input  64  unsigned product from upstream 32x32 multiplier.
REQ-006 Port din_vld  input  1  din valid; no backpressure to upstream; every valid beat is consumed.
REQ-007 Port acc_clr  input  1  synchronous abort: discard partial frame.
REQ-008 Port dout  output  ACC_W  frame sum.
REQ-009 Port dout_vld  output  1  dout valid, held until accepted.
REQ-010 Port dout_rdy  input  1  downstream accept; transfer when dout_vld && dout_rdy.
REQ-011 Port busy  output  1  high while a frame is partially accumulated (state ACC).
REQ-012 Port err_ovf  output  1  sticky: a completed frame overwrote an unaccepted result.

Function
REQ-013 FSM states IDLE (beat count 0) and ACC (1..FRAME_LEN-1 beats taken); busy SHALL equal (state==ACC).
REQ-014 IDLE + din_vld: acc <= din, cnt <= 1, go ACC (FRAME_LEN>=2).
REQ-015 ACC + din_vld, not last beat: acc <= acc + din (unsigned, zero-extended to ACC_W), cnt <= cnt+1.
REQ-016 ACC + din_vld on beat FRAME_LEN: dout <= acc + din, dout_vld <= 1, acc <= 0, cnt <= 0, go IDLE.
REQ-017 Latency: dout_vld SHALL rise the cycle after the last din_vld beat of a frame.
REQ-018 din_vld low: acc, cnt, state hold; gaps between beats of any length allowed.
REQ-019 Accumulation SHALL continue independent of output stall; output is a separate one-deep holding register.
REQ-020 dout/dout_vld SHALL stay stable while dout_vld && !dout_rdy.
REQ-021 Transfer without new result: dout_vld <= 0 next cycle; dout value don't-care after.
REQ-022 Transfer and new frame completion same cycle: new sum loaded, dout_vld stays 1, err_ovf unchanged.
REQ-023 Frame completion while dout_vld && !dout_rdy: new sum overwrites dout, err_ovf <= 1 (sticky until rst).
REQ-024 dout_rdy while dout_vld low SHALL be ignored.
REQ-025 acc_clr: acc <= 0, cnt <= 0, go IDLE; takes priority over din_vld same cycle (that beat discarded); output register and err_ovf unaffected.
REQ-026 No wrap within a frame: with ACC_W rule of REQ-002, sum of FRAME_LEN maximal products SHALL be exact.

Reset
REQ-027 rst SHALL force: state IDLE, acc 0, cnt 0, dout 0, dout_vld 0, busy 0, err_ovf 0, next edge, overriding all inputs.
REQ-028 rst mid-frame or with result pending SHALL discard both; first din_vld after rst deasserts starts a new frame.

Structure
REQ-029 Shared package/include mult_acc_pkg SHALL hold FRAME_LEN/ACC_W defaults, state encodings and the clog2 width helper, shared with the multiplier bench.
REQ-030 One sub-module acc_out_hold SHALL implement the output holding register, dout_vld/dout_rdy handshake and err_ovf; FSM and adder stay in top.

Verification
REQ-031 16 beats din=1 back-to-back, dout_rdy=1 -> one dout_vld pulse, dout=16, err_ovf=0.
REQ-032 16 beats din=64'hFFFF_FFFF_FFFF_FFFF -> dout=72'h0F_FFFF_FFFF_FFFF_FFF0, exact, no wrap.
REQ-033 dout_rdy=0, two frames of din=1 then din=2 -> dout=32 after second frame, err_ovf=1; raise dout_rdy -> dout_vld falls next cycle.
REQ-034 8 beats din=5, acc_clr with simultaneous din_vld, then 16 beats din=3 -> only dout=48 reported, busy low after clr.
REQ-035 Random gaps in din_vld with 20 random products from 32x32 multiplier feed, FRAME_LEN=4 -> 5 results matching reference-model sums, dout stable under random dout_rdy.
REQ-036 rst asserted at beat 10 of a frame and with result pending -> all outputs 0 next cycle; next 16 beats din=1 -> dout=16.
